// File: rtl/frame1035_pkg.sv
// rtl/frame1035_pkg.sv - shared types and constants for the 1035 frame link
// Contents: transmit FSM state enum, the 1035 code word, the link word width.
package frame1035_pkg;

    localparam int          WORD_W    = 16;
    localparam logic [15:0] CODE_1035 = 16'h040B;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAY,
        TRL,
        DONE
    } tx_state_t;

endpackage

// File: rtl/out_stage1035.sv
// rtl/out_stage1035.sv - registered output word stage with valid/last
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   load, load_data,      word offered for the register; taken only when the
//   load_last             slot is free
//   out_ready             downstream accept
//   out_data, out_valid,  registered word towards the link
//   out_last
//   slot_free             register may be (re)loaded this cycle
module out_stage1035
    import frame1035_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic              load_last,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    output logic              slot_free
);

    // Empty register, or the held word transfers on this edge.
    assign slot_free = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (slot_free) begin
            if (load) begin
                out_data  <= load_data;
                out_valid <= 1'b1;
                out_last  <= load_last;
            end else begin
                // Word left (or none held) and nothing replaces it: go empty,
                // data is kept so no bubble value is ever presented as valid.
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/frame_tx1035.sv
// rtl/frame_tx1035.sv - 1035 frame transmitter: header, payload, XOR trailer
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, len                  frame request and payload count (IDLE only)
//   busy                        high outside IDLE
//   in_data, in_valid, in_ready payload stream in
//   out_data, out_valid,        frame words out, out_last marks the trailer
//   out_ready, out_last
module frame_tx1035
    import frame1035_pkg::*;
#(
    parameter logic [15:0] CODE  = CODE_1035,
    parameter int          LEN_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    tx_state_t         state;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt;
    logic [WORD_W-1:0] csum;

    logic              slot_free;
    logic              in_fire;
    logic              ld;
    logic [WORD_W-1:0] ld_data;
    logic              ld_last;
    logic [LEN_W-1:0]  len_m1;

    assign busy     = (state != IDLE);
    assign in_ready = (state == PAY) && slot_free;
    assign in_fire  = in_valid && in_ready;
    // Terminal compare against len-1 keeps the counter inside LEN_W bits
    // even for the largest frame; only reached in PAY, where len_q != 0.
    assign len_m1   = len_q - LEN_W'(1);

    always_comb begin
        ld      = 1'b0;
        ld_data = CODE;
        ld_last = 1'b0;
        case (state)
            HDR: ld = slot_free;
            PAY: begin
                ld      = in_fire;
                ld_data = in_data;
            end
            TRL: begin
                ld      = slot_free;
                ld_data = csum;
                ld_last = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            len_q <= '0;
            cnt   <= '0;
            csum  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q <= len;
                        cnt   <= '0;
                        csum  <= '0;
                        state <= HDR;
                    end
                end
                HDR: begin
                    if (slot_free) begin
                        state <= (len_q != '0) ? PAY : TRL;
                    end
                end
                PAY: begin
                    if (in_fire) begin
                        csum <= csum ^ in_data;
                        cnt  <= cnt + LEN_W'(1);
                        if (cnt == len_m1) begin
                            state <= TRL;
                        end
                    end
                end
                TRL: begin
                    if (slot_free) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Trailer is held in the stage; leave once it transfers.
                    if (out_valid && out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    out_stage1035 u_out (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ld),
        .load_data (ld_data),
        .load_last (ld_last),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .slot_free (slot_free)
    );

endmodule

// File: tb/tb_frame_tx1035.sv
// tb/tb_frame_tx1035.sv - directed self-checking bench for frame_tx1035
module tb_frame_tx1035;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic        busy;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    int n_chk  = 0;
    int n_pass = 0;

    logic [15:0] pay[$];
    logic [15:0] exp_d[$];
    logic [15:0] bd[$];
    logic        bl[$];
    logic        saw_in_ready;
    logic        saw_drop;
    int          first_c;
    int          last_c;

    always #5 clk = ~clk;

    frame_tx1035 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic start_frame(input logic [7:0] l);
        @(posedge clk); #1;
        start = 1'b1;
        len   = l;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", {31'b0, busy}, 32'd1);
        chk("hdr_not_yet", {31'b0, out_valid}, 32'd0);
    endtask

    // Starts at #1 after a rising edge; returns #1 after the edge on which
    // the last-flagged word transferred.
    task automatic run(input logic [31:0] rdy_pat, input logic [31:0] vld_pat,
                       input logic [31:0] st_pat);
        int          pi;
        logic        done;
        logic        stalled;
        logic [15:0] pd;
        logic        pl;
        pi = 0; done = 1'b0; stalled = 1'b0; pd = '0; pl = 1'b0;
        bd.delete(); bl.delete();
        saw_in_ready = 1'b0; saw_drop = 1'b0; first_c = -1; last_c = -1;
        for (int c = 0; c < 64 && !done; c++) begin
            out_ready = (c < 32) ? rdy_pat[c] : 1'b1;
            in_valid  = (pi < pay.size()) && ((c < 32) ? vld_pat[c] : 1'b1);
            in_data   = (pi < pay.size()) ? pay[pi] : 16'h0000;
            start     = (c < 32) ? st_pat[c] : 1'b0;
            len       = 8'd5;
            @(negedge clk);
            if (stalled) begin
                chk("hold_data", {16'b0, out_data}, {16'b0, pd});
                chk("hold_last", {31'b0, out_last}, {31'b0, pl});
                chk("hold_valid", {31'b0, out_valid}, 32'd1);
            end
            stalled = out_valid && !out_ready;
            pd = out_data;
            pl = out_last;
            if (stalled) chk("in_ready_stall", {31'b0, in_ready}, 32'd0);
            if (in_ready) saw_in_ready = 1'b1;
            if (bd.size() > 0 && !out_valid && busy) saw_drop = 1'b1;
            if (in_valid && in_ready) pi++;
            if (out_valid && out_ready) begin
                bd.push_back(out_data);
                bl.push_back(out_last);
                if (first_c < 0) first_c = c;
                last_c = c;
                if (out_last) done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) chk("frame_timeout", 32'd0, 32'd1);
        start    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic cmp_beats(input string tag);
        int n;
        chk($sformatf("%s_nbeats", tag), bd.size(), exp_d.size());
        n = (bd.size() < exp_d.size()) ? bd.size() : exp_d.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_data%0d", tag, i), {16'b0, bd[i]}, {16'b0, exp_d[i]});
            chk($sformatf("%s_last%0d", tag, i), {31'b0, bl[i]},
                (i == exp_d.size() - 1) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; len = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", {16'b0, out_data}, 32'd0);
        chk("rst_out_last", {31'b0, out_last}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        rst_n = 1'b1;

        // len=3, continuous flow
        pay = '{16'h1111, 16'h2222, 16'h4444};
        start_frame(8'd3);
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
        exp_d = '{16'h040B, 16'h1111, 16'h2222, 16'h4444, 16'h7777};
        cmp_beats("len3");
        chk("len3_consecutive", last_c - first_c, 32'd4);
        chk("len3_no_drop", {31'b0, saw_drop}, 32'd0);
        chk("len3_busy_end", {31'b0, busy}, 32'd0);

        // len=0: header then zero checksum
        pay = {};
        start_frame(8'd0);
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
        exp_d = '{16'h040B, 16'h0000};
        cmp_beats("len0");
        chk("len0_no_in_ready", {31'b0, saw_in_ready}, 32'd0);
        chk("len0_busy_end", {31'b0, busy}, 32'd0);

        // backpressure, payload containing the code word
        pay = '{16'hABCD, 16'h040B};
        start_frame(8'd2);
        run(32'hFFFF_FFF3, 32'hFFFF_FFFF, 32'h0);
        exp_d = '{16'h040B, 16'hABCD, 16'h040B, 16'hAFC6};
        cmp_beats("bp");

        // upstream gap of three cycles
        pay = '{16'h1234, 16'h5678, 16'h9ABC};
        start_frame(8'd3);
        run(32'hFFFF_FFFF, 32'hFFFF_FFE3, 32'h0);
        exp_d = '{16'h040B, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        cmp_beats("gap");
        chk("gap_valid_drop", {31'b0, saw_drop}, 32'd1);

        // start pulsed in PAY and in DONE is ignored
        pay = '{16'hBEEF};
        start_frame(8'd1);
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_000A);
        exp_d = '{16'h040B, 16'hBEEF, 16'hBEEF};
        cmp_beats("ign");
        chk("ign_idle_after", {31'b0, busy}, 32'd0);
        // new start in the first IDLE cycle
        start = 1'b1;
        len   = 8'd1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_busy", {31'b0, busy}, 32'd1);
        pay = '{16'h040B};
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
        exp_d = '{16'h040B, 16'h040B, 16'h040B};
        cmp_beats("b2b");
        chk("b2b_busy_end", {31'b0, busy}, 32'd0);

        // asynchronous reset mid-payload
        pay = {};
        start_frame(8'd3);
        in_valid = 1'b1; in_data = 16'h1111; out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_out_last", {31'b0, out_last}, 32'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        pay = '{16'hBEEF};
        start_frame(8'd1);
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
        exp_d = '{16'h040B, 16'hBEEF, 16'hBEEF};
        cmp_beats("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
